// File: rtl/mult_cell_sequencer_pkg.sv
// Shared types and constants for the 32x32 multiply sequencer around the 16x16 cell.
package mult_cell_sequencer_pkg;

    localparam int unsigned MUL_W  = 32;
    localparam int unsigned HALF_W = 16;

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULXUU = 2'd1,
        OP_MULXSS = 2'd2,
        OP_MULXSU = 2'd3
    } op_e;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StLoIssue = 3'd1;
    localparam logic [2:0] StLoWait  = 3'd2;
    localparam logic [2:0] StLoCap   = 3'd3;
    localparam logic [2:0] StHiIssue = 3'd4;
    localparam logic [2:0] StHiWait  = 3'd5;
    localparam logic [2:0] StHiCap   = 3'd6;
    localparam logic [2:0] StDone    = 3'd7;

endpackage

// File: rtl/mult_hi_correct.sv
// Assembles the unsigned high word from the partial products and applies the
// signed correction terms for MULXSS / MULXSU.
module mult_hi_correct
    import mult_cell_sequencer_pkg::*;
(
    input  logic [MUL_W-1:0] hh,
    input  logic [MUL_W:0]   mid,
    input  logic [MUL_W-1:0] p1,
    input  logic [MUL_W-1:0] a,
    input  logic [MUL_W-1:0] b,
    input  op_e              op,
    output logic [MUL_W-1:0] hi
);

    logic [2*MUL_W-1:0] full_u;
    logic [MUL_W-1:0]   hi_u;
    logic [MUL_W-1:0]   corr_a;
    logic [MUL_W-1:0]   corr_b;

    always_comb begin
        full_u = {hh, {MUL_W{1'b0}}}
               + {{(MUL_W-HALF_W-1){1'b0}}, mid, {HALF_W{1'b0}}}
               + {{MUL_W{1'b0}}, p1};
        hi_u   = full_u[2*MUL_W-1:MUL_W];
        // A negative operand read as unsigned adds 2^32 * other; remove it from the high word.
        corr_a = a[MUL_W-1] ? b : '0;
        corr_b = b[MUL_W-1] ? a : '0;
        case (op)
            OP_MULXSS: hi = hi_u - corr_a - corr_b;
            OP_MULXSU: hi = hi_u - corr_a;
            default:   hi = hi_u;
        endcase
    end

endmodule

// File: rtl/mult_cell_sequencer.sv
// Runs one 32x32 multiply at a time through the 16x16 three-product cell:
// a low pass for p1/p2/p3, plus a second pass for a_hi*b_hi on high-word ops.
module mult_cell_sequencer
    import mult_cell_sequencer_pkg::*;
#(
    parameter int unsigned CELL_LAT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [MUL_W-1:0] req_a,
    input  logic [MUL_W-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [MUL_W-1:0] rsp_result,
    output logic             busy,
    output logic [MUL_W-1:0] cell_src1,
    output logic [MUL_W-1:0] cell_src2,
    output logic             cell_en,
    input  logic [MUL_W-1:0] cell_p1,
    input  logic [MUL_W-1:0] cell_p2,
    input  logic [MUL_W-1:0] cell_p3
);

    localparam int unsigned CntW = 2;

    logic [2:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [MUL_W-1:0] a_q, a_d, b_q, b_d;
    logic [MUL_W-1:0] p1_q, p1_d, result_q, result_d;
    logic [MUL_W:0]   mid_q, mid_d, mid_now;
    op_e              op_q, op_d;
    logic [MUL_W-1:0] hi_word;

    assign mid_now = {1'b0, cell_p2} + {1'b0, cell_p3};

    mult_hi_correct u_hi_correct (
        .hh  (cell_p1),
        .mid (mid_q),
        .p1  (p1_q),
        .a   (a_q),
        .b   (b_q),
        .op  (op_q),
        .hi  (hi_word)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        p1_d     = p1_q;
        mid_d    = mid_q;
        result_d = result_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    op_d    = op_e'(req_op);
                    state_d = StLoIssue;
                end
            end
            StLoIssue, StHiIssue: begin
                cnt_d = CntW'(CELL_LAT - 1);
                if (CELL_LAT > 1) begin
                    state_d = (state_q == StLoIssue) ? StLoWait : StHiWait;
                end else begin
                    state_d = (state_q == StLoIssue) ? StLoCap : StHiCap;
                end
            end
            StLoWait, StHiWait: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CntW'(1)) begin
                    state_d = (state_q == StLoWait) ? StLoCap : StHiCap;
                end
            end
            StLoCap: begin
                p1_d  = cell_p1;
                mid_d = mid_now;
                if (op_q == OP_MUL) begin
                    result_d = cell_p1 + {mid_now[HALF_W-1:0], {HALF_W{1'b0}}};
                    state_d  = StDone;
                end else begin
                    state_d = StHiIssue;
                end
            end
            StHiCap: begin
                result_d = hi_word;
                state_d  = StDone;
            end
            StDone: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_MUL;
            p1_q     <= '0;
            mid_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            p1_q     <= p1_d;
            mid_q    <= mid_d;
            result_q <= result_d;
        end
    end

    // Operands stay on the cell for the whole pass so its inputs never glitch mid-wait.
    always_comb begin
        cell_src1 = '0;
        cell_src2 = '0;
        case (state_q)
            StLoIssue, StLoWait, StLoCap: begin
                cell_src1 = a_q;
                cell_src2 = b_q;
            end
            StHiIssue, StHiWait, StHiCap: begin
                cell_src1 = {{HALF_W{1'b0}}, a_q[MUL_W-1:HALF_W]};
                cell_src2 = {{HALF_W{1'b0}}, b_q[MUL_W-1:HALF_W]};
            end
            default: ;
        endcase
    end

    assign cell_en    = (state_q == StLoIssue) || (state_q == StHiIssue);
    assign req_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign rsp_valid  = (state_q == StDone);
    assign rsp_result = result_q;

endmodule

// File: tb/tb_mult_cell_sequencer.sv
// Scoreboard bench: three sequencers (CELL_LAT 1..3), each with its own cell model,
// driver and monitor, checked against a 64-bit arithmetic reference.
module tb_mult_cell_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks   = 0;
    int failures = 0;
    int n_done   = 0;

    task automatic chk(input string name, input int lat, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (CELL_LAT=%0d) at cycle %0d: actual=%h required=%h",
                     name, lat, cyc, act, exp);
        end
    endtask

    // Reference: full product from plain signed/unsigned 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] prod;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (op)
            2'd0:    prod = ua * ub;
            2'd1:    prod = ua * ub;
            2'd2:    prod = sa * sb;
            default: prod = sa * ub;
        endcase
        return (op == 2'd0) ? prod[31:0] : prod[63:32];
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input int lat);
        return (op == 2'd0) ? 2 + lat : 3 + 2 * lat;
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_lat
        localparam int LAT = g + 1;

        logic        reset_n   = 1'b0;
        logic        req_valid = 1'b0;
        logic        rsp_ready = 1'b0;
        logic [1:0]  req_op    = 2'd0;
        logic [31:0] req_a     = 32'd0;
        logic [31:0] req_b     = 32'd0;
        logic        req_ready, rsp_valid, busy, cell_en;
        logic [31:0] rsp_result, cell_src1, cell_src2;
        logic [31:0] cell_p1, cell_p2, cell_p3;
        logic [31:0] prod1, prod2, prod3;
        logic [95:0] stg [LAT];
        int          rdy_mode = 0;
        logic [31:0] exp_q [$];

        mult_cell_sequencer #(.CELL_LAT(LAT)) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .req_valid  (req_valid),
            .req_ready  (req_ready),
            .req_op     (req_op),
            .req_a      (req_a),
            .req_b      (req_b),
            .rsp_valid  (rsp_valid),
            .rsp_ready  (rsp_ready),
            .rsp_result (rsp_result),
            .busy       (busy),
            .cell_src1  (cell_src1),
            .cell_src2  (cell_src2),
            .cell_en    (cell_en),
            .cell_p1    (cell_p1),
            .cell_p2    (cell_p2),
            .cell_p3    (cell_p3)
        );

        // Cell model: enabled capture, then LAT-1 plain delay stages.
        assign prod1 = {16'd0, cell_src1[15:0]} * {16'd0, cell_src2[15:0]};
        assign prod2 = {16'd0, cell_src1[15:0]} * {16'd0, cell_src2[31:16]};
        assign prod3 = {16'd0, cell_src1[31:16]} * {16'd0, cell_src2[15:0]};
        always @(posedge clk) begin
            if (cell_en) stg[0] <= {prod1, prod2, prod3};
            for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
        end
        assign {cell_p1, cell_p2, cell_p3} = stg[LAT-1];

        always @(posedge clk) begin
            #1;
            case (rdy_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = ($urandom_range(0, 3) != 0);
                default: rsp_ready = 1'b0;
            endcase
        end

        // Monitor
        int          fire_cyc = 0;
        int          en_cnt   = 0;
        int          quiet    = 0;
        logic [1:0]  fire_op  = 2'd0;
        logic        resp_open = 1'b0;
        logic        pend_acc  = 1'b0;
        logic [31:0] first_res = 32'd0;
        logic [31:0] exp_res;

        always @(negedge clk) begin
            if (!reset_n) begin
                chk("rst_rsp_valid", LAT, rsp_valid, 0);
                chk("rst_req_ready", LAT, req_ready, 1);
                chk("rst_busy", LAT, busy, 0);
                chk("rst_cell_en", LAT, cell_en, 0);
                chk("rst_rsp_result", LAT, rsp_result, 0);
                chk("rst_cell_src1", LAT, cell_src1, 0);
                chk("rst_cell_src2", LAT, cell_src2, 0);
                exp_q.delete();
                resp_open = 1'b0;
                pend_acc  = 1'b0;
                quiet     = 8;
            end else begin
                if (quiet > 0) begin
                    chk("post_rst_rsp_valid", LAT, rsp_valid, 0);
                    chk("post_rst_req_ready", LAT, req_ready, 1);
                    quiet--;
                end
                if (pend_acc && req_valid) chk("queued_accept_ready", LAT, req_ready, 1);
                pend_acc = 1'b0;
                if (cell_en) en_cnt++;
                if (req_valid && req_ready) begin
                    fire_cyc = cyc + 1;
                    fire_op  = req_op;
                    en_cnt   = 0;
                end
                if (rsp_valid) begin
                    chk("rsp_req_ready_low", LAT, req_ready, 0);
                    chk("rsp_busy", LAT, busy, 1);
                    if (!resp_open) begin
                        resp_open = 1'b1;
                        first_res = rsp_result;
                        chk("latency", LAT, cyc + 1 - fire_cyc, exp_lat(fire_op, LAT));
                    end else begin
                        chk("rsp_stable", LAT, rsp_result, first_res);
                    end
                    if (rsp_ready) begin
                        chk("rsp_expected", LAT, exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin
                            exp_res = exp_q.pop_front();
                            chk("result", LAT, rsp_result, exp_res);
                            chk("cell_en_cycles", LAT, en_cnt, (fire_op == 2'd0) ? 1 : 2);
                        end
                        resp_open = 1'b0;
                        pend_acc  = req_valid;
                    end
                end
            end
        end

        task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
            bit got = 1'b0;
            exp_q.push_back(ref_model(op, a, b));
            req_op    = op;
            req_a     = a;
            req_b     = b;
            req_valid = 1'b1;
            for (int i = 0; i < 400 && !got; i++) begin
                @(negedge clk);
                if (req_ready) got = 1'b1;
            end
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            if (!got) chk("accept_timeout", LAT, 0, 1);
        endtask

        task automatic drain();
            for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(posedge clk);
            chk("drain", LAT, exp_q.size(), 0);
            #1;
        endtask

        initial begin
            int seen;
            repeat (3) @(posedge clk);
            #1 reset_n = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            issue(2'd0, 32'h0001_0003, 32'h0002_0005);
            issue(2'd1, 32'h0001_0003, 32'h0002_0005);
            for (int op = 0; op < 4; op++) issue(2'(op), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            issue(2'd2, 32'h8000_0000, 32'h8000_0000);
            issue(2'd3, 32'h8000_0000, 32'h8000_0000);
            drain();

            // Response held in DONE with a second request queued behind it.
            rdy_mode = 2;
            issue(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
            fork
                issue(2'd3, 32'hDEAD_BEEF, 32'h0BAD_F00D);
                begin
                    repeat (12) @(posedge clk);
                    #1 rdy_mode = 0;
                end
            join
            drain();
            for (int i = 0; i < 4; i++) issue(2'd0, $urandom, $urandom);
            drain();

            // Reset during the high pass: the op must vanish without a response.
            issue(2'd2, 32'hF00D_CAFE, 32'h8765_4321);
            seen = 0;
            for (int i = 0; i < 60 && seen < 2; i++) begin
                @(negedge clk);
                if (cell_en) seen++;
            end
            @(posedge clk);
            #1 reset_n = 1'b0;
            repeat (2) @(posedge clk);
            #1 reset_n = 1'b1;
            repeat (10) @(posedge clk);
            #1;

            rdy_mode = 1;
            for (int n = 0; n < 1500; n++) issue(2'($urandom_range(0, 3)), rnd_word(), rnd_word());
            drain();
            n_done++;
        end
    end

    initial begin
        for (int i = 0; i < 90000 && n_done < 3; i++) @(posedge clk);
        if (n_done < 3) begin
            failures++;
            $display("FAIL global_timeout: finished=%0d required=3", n_done);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
